// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA test-pattern colour stage.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int BAR_W_DEF    = 80;

    typedef enum logic [1:0] {
        MODE_XOR   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GREY  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Sync inputs from the timing generator, pattern select, and the
// delayed sync plus colour outputs heading to the DAC.
interface vga_pattern_gen_if;

    logic       hs_in;
    logic       vs_in;
    logic       blank_n_in;
    logic [1:0] mode;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] frame;

    modport master (
        output hs_in, vs_in, blank_n_in, mode,
        input  hs, vs, blank_n, r, g, b, frame
    );

    modport slave (
        input  hs_in, vs_in, blank_n_in, mode,
        output hs, vs, blank_n, r, g, b, frame
    );

endinterface

// File: rtl/vga_pos_tracker.sv
// Stage 0: recovers pixel coordinates, colour-bar index, frame count and
// the frame-synchronous pattern mode from the incoming sync signals.
module vga_pos_tracker
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BAR_W    = BAR_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_vs,
    input  logic       i_blank_n,
    input  logic [1:0] i_mode,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_bar_idx,
    output logic [7:0] o_frame,
    output mode_e      o_mode_act
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int BW = $clog2(BAR_W);
    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [XW-1:0] r_x_cnt;
    logic [YW-1:0] r_y_cnt;
    logic [BW-1:0] r_bar_cnt;
    logic [2:0]    r_bar_idx;
    logic          r_blank_d;
    logic          r_vs_d;
    logic [1:0]    r_mode_s1;
    logic [1:0]    r_mode_s2;
    logic [7:0]    r_frame;
    mode_e         r_mode_act;

    logic w_blank_fall;
    logic w_vs_fall;

    assign w_blank_fall = r_blank_d & ~i_blank_n;
    assign w_vs_fall    = r_vs_d & ~i_vs;

    // Horizontal position and bar index: cleared in blanking, saturating counts while active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_cnt   <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!i_blank_n) begin
            r_x_cnt   <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else begin
            if (r_x_cnt != X_LAST)
                r_x_cnt <= r_x_cnt + XW'(1);
            if (r_bar_cnt == BAR_LAST) begin
                r_bar_cnt <= '0;
                if (r_bar_idx != 3'd7)
                    r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + BW'(1);
            end
        end
    end

    // Line count: vsync low clears (and wins over a coincident blank fall), each line end increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_cnt   <= '0;
            r_blank_d <= 1'b0;
        end else begin
            r_blank_d <= i_blank_n;
            if (!i_vs)
                r_y_cnt <= '0;
            else if (w_blank_fall && (r_y_cnt != Y_LAST))
                r_y_cnt <= r_y_cnt + YW'(1);
        end
    end

    // Frame counter and mode capture, both on the vsync falling edge so patterns never tear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d     <= 1'b1;
            r_mode_s1  <= 2'd0;
            r_mode_s2  <= 2'd0;
            r_frame    <= 8'd0;
            r_mode_act <= MODE_XOR;
        end else begin
            r_vs_d    <= i_vs;
            r_mode_s1 <= i_mode;
            r_mode_s2 <= r_mode_s1;
            if (w_vs_fall) begin
                r_frame    <= r_frame + 8'd1;
                r_mode_act <= mode_e'(r_mode_s2);
            end
        end
    end

    assign o_x        = r_x_cnt[7:0];
    assign o_y        = r_y_cnt[7:0];
    assign o_bar_idx  = r_bar_idx;
    assign o_frame    = r_frame;
    assign o_mode_act = r_mode_act;

endmodule

// File: rtl/vga_pattern_gen.sv
// Colour stage behind the VGA sync generator: tags each sample with its
// coordinates, generates the selected test pattern and keeps the syncs
// aligned with the colour data (two-cycle latency end to end).
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BAR_W    = BAR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_pattern_gen_if.slave   bus
);

    logic [7:0] w_x;
    logic [7:0] w_y;
    logic [2:0] w_bar_idx;
    logic [7:0] w_frame;
    mode_e      w_mode_act;
    rgb_t       w_pix;

    logic [7:0] r_x_p1;
    logic [7:0] r_y_p1;
    logic [2:0] r_bar_p1;
    logic       r_hs_p1;
    logic       r_vs_p1;
    logic       r_blank_p1;

    logic       r_hs_p2;
    logic       r_vs_p2;
    logic       r_blank_p2;
    rgb_t       r_pix_p2;

    vga_pos_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BAR_W    (BAR_W)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vs       (bus.vs_in),
        .i_blank_n  (bus.blank_n_in),
        .i_mode     (bus.mode),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_bar_idx  (w_bar_idx),
        .o_frame    (w_frame),
        .o_mode_act (w_mode_act)
    );

    function automatic rgb_t pixel_colour(
        input mode_e      m,
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [2:0] bar,
        input logic [7:0] frm,
        input logic       active
    );
        rgb_t       c;
        logic [7:0] p;
        logic [7:0] chk;
        c   = '0;
        p   = x ^ y;
        chk = {8{x[5] ^ y[5]}};
        if (active) begin
            case (m)
                MODE_XOR:   c = '{r: p, g: p + frm, b: y ^ frm};
                MODE_BARS:  c = '{r: {8{bar[2]}}, g: {8{bar[1]}}, b: {8{bar[0]}}};
                MODE_CHECK: c = '{r: chk, g: chk, b: chk};
                MODE_GREY:  c = '{r: frm, g: frm, b: frm};
            endcase
        end
        return c;
    endfunction

    assign w_pix = pixel_colour(w_mode_act, r_x_p1, r_y_p1, r_bar_p1, w_frame, r_blank_p1);

    // ---- stage 0 -> stage 1 boundary ----
    // Register the coordinate tags alongside the raw syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_p1     <= '0;
            r_y_p1     <= '0;
            r_bar_p1   <= '0;
            r_hs_p1    <= 1'b1;
            r_vs_p1    <= 1'b1;
            r_blank_p1 <= 1'b0;
        end else begin
            r_x_p1     <= w_x;
            r_y_p1     <= w_y;
            r_bar_p1   <= w_bar_idx;
            r_hs_p1    <= bus.hs_in;
            r_vs_p1    <= bus.vs_in;
            r_blank_p1 <= bus.blank_n_in;
        end
    end

    // ---- stage 1 -> stage 2 boundary ----
    // Register colour and syncs together so they reach the DAC on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_p2    <= 1'b1;
            r_vs_p2    <= 1'b1;
            r_blank_p2 <= 1'b0;
            r_pix_p2   <= '0;
        end else begin
            r_hs_p2    <= r_hs_p1;
            r_vs_p2    <= r_vs_p1;
            r_blank_p2 <= r_blank_p1;
            r_pix_p2   <= w_pix;
        end
    end

    assign bus.hs      = r_hs_p2;
    assign bus.vs      = r_vs_p2;
    assign bus.blank_n = r_blank_p2;
    assign bus.r       = r_pix_p2.r;
    assign bus.g       = r_pix_p2.g;
    assign bus.b       = r_pix_p2.b;
    assign bus.frame   = w_frame;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed sync timing plus a per-cycle
// behavioural model of pixel position, frame count and pattern colour.
module tb_vga_pattern_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_pattern_gen_if bus ();

    vga_pattern_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [23:0] cap_rgb [0:719];
    logic        cap_bl  [0:719];

    // model state
    int          m_run;
    int          m_y;
    int          m_frame;
    logic [1:0]  m_mode;
    logic        m_pblank;
    logic        m_pvs;
    logic        e_hs;
    logic        e_vs;
    logic        e_bl;
    logic [23:0] e_rgb;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Per-cycle model: the outputs after an edge describe the sample taken one edge earlier.
    always @(posedge clk) begin
        logic        hs_i;
        logic        vs_i;
        logic        bl_i;
        int          xt;
        int          yt;
        int          bt;
        logic [7:0]  x8;
        logic [7:0]  y8;
        logic [7:0]  f8;
        logic [7:0]  p8;
        logic [7:0]  g8;
        logic [7:0]  k8;
        logic [23:0] c;
        logic        ok;
        #2;
        if (!rst_n) begin
            m_run    = 0;
            m_y      = 0;
            m_frame  = 0;
            m_mode   = 2'd0;
            m_pblank = 1'b0;
            m_pvs    = 1'b1;
            e_hs     = 1'b1;
            e_vs     = 1'b1;
            e_bl     = 1'b0;
            e_rgb    = 24'h0;
        end else begin
            hs_i = bus.hs_in;
            vs_i = bus.vs_in;
            bl_i = bus.blank_n_in;
            if (m_pvs && !vs_i) begin
                m_frame = (m_frame + 1) % 256;
                m_mode  = bus.mode;
            end
            xt = (m_run > 639) ? 639 : m_run;
            bt = ((m_run / 80) > 7) ? 7 : (m_run / 80);
            yt = m_y;
            x8 = xt[7:0];
            y8 = yt[7:0];
            f8 = m_frame[7:0];
            c  = 24'h0;
            if (bl_i) begin
                case (m_mode)
                    2'd0: begin
                        p8 = x8 ^ y8;
                        g8 = p8 + f8;
                        c  = {p8, g8, y8 ^ f8};
                    end
                    2'd1: c = {{8{bt[2]}}, {8{bt[1]}}, {8{bt[0]}}};
                    2'd2: begin
                        k8 = {8{x8[5] ^ y8[5]}};
                        c  = {k8, k8, k8};
                    end
                    default: c = {f8, f8, f8};
                endcase
            end
            total++;
            ok = (bus.hs === e_hs) && (bus.vs === e_vs) && (bus.blank_n === e_bl) &&
                 ({bus.r, bus.g, bus.b} === e_rgb) && (bus.frame === f8);
            if (!ok) begin
                bad++;
                $display("FAIL pipe t=%0t: got hs=%b vs=%b bl=%b rgb=%h frame=%0d, required hs=%b vs=%b bl=%b rgb=%h frame=%0d",
                         $time, bus.hs, bus.vs, bus.blank_n, {bus.r, bus.g, bus.b}, bus.frame,
                         e_hs, e_vs, e_bl, e_rgb, f8);
            end
            e_hs  = hs_i;
            e_vs  = vs_i;
            e_bl  = bl_i;
            e_rgb = c;
            m_run = bl_i ? m_run + 1 : 0;
            if (!vs_i)
                m_y = 0;
            else if (m_pblank && !bl_i && m_y < 479)
                m_y = m_y + 1;
            m_pblank = bl_i;
            m_pvs    = vs_i;
        end
    end

    // One line: n_act visible samples then n_blk blanked; capture outputs of this line's samples.
    task automatic send_line(input int n_act, input int n_blk, input bit vs_low, input bit cap);
        for (int h = 0; h < n_act + n_blk; h++) begin
            @(negedge clk);
            if (cap && h >= 2 && (h - 2) < 720) begin
                cap_rgb[h-2] = {bus.r, bus.g, bus.b};
                cap_bl[h-2]  = bus.blank_n;
            end
            bus.blank_n_in = (h < n_act) && !vs_low;
            bus.vs_in      = !vs_low;
            bus.hs_in      = !((n_blk >= 12) && (h >= n_act + 4) && (h < n_act + 12));
        end
    endtask

    // Shortened frame: 11 visible lines, one vsync line, one back-porch line.
    task automatic send_frame(input int cap_y, input int chg_line, input logic [1:0] chg_mode);
        for (int v = 0; v < 11; v++) begin
            if (v == chg_line)
                bus.mode = chg_mode;
            send_line(640, 16, 1'b0, v == cap_y);
        end
        send_line(0, 656, 1'b1, 1'b0);
        send_line(0, 656, 1'b0, 1'b0);
    endtask

    initial begin
        bus.hs_in      = 1'b1;
        bus.vs_in      = 1'b1;
        bus.blank_n_in = 1'b0;
        bus.mode       = 2'd0;

        repeat (3) @(negedge clk);
        check("reset_vals", {bus.hs, bus.vs, bus.blank_n, bus.r, bus.g, bus.b, bus.frame},
              {1'b1, 1'b1, 1'b0, 24'h0, 8'h0});

        // release and drive constant-high syncs
        @(negedge clk);
        rst_n          = 1'b1;
        bus.blank_n_in = 1'b1;
        @(negedge clk);
        check("blank_lat1", bus.blank_n, 1'b0);
        @(negedge clk);
        check("blank_lat2", bus.blank_n, 1'b1);
        repeat (3) @(negedge clk);
        bus.hs_in = 1'b0;
        @(negedge clk);
        check("hs_lat1", bus.hs, 1'b1);
        @(negedge clk);
        check("hs_lat2", bus.hs, 1'b0);
        check("xor_x5_startup", {bus.r, bus.g, bus.b}, 24'h050500);

        // asynchronous reset mid-line
        #2 rst_n = 1'b0;
        #1 check("async_reset", {bus.hs, bus.vs, bus.blank_n, bus.r, bus.g, bus.b},
                 {1'b1, 1'b1, 1'b0, 24'h0});
        @(negedge clk);
        bus.hs_in      = 1'b1;
        bus.blank_n_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // XOR pattern
        send_frame(-1, -1, 2'd0);
        send_frame(0, 5, 2'd1);
        check("xor_x5_y0", cap_rgb[5], 24'h050601);
        check("xor_x0_y0", cap_rgb[0], 24'h000101);
        check("xor_blank_rgb", cap_rgb[645], 24'h0);
        check("xor_blank_flag", cap_bl[645], 1'b0);
        check("xor_last_active", cap_bl[639], 1'b1);

        // colour bars
        send_frame(10, 2, 2'd2);
        check("bars_x0", cap_rgb[0], 24'h000000);
        check("bars_x79", cap_rgb[79], 24'h000000);
        check("bars_x80", cap_rgb[80], 24'h0000FF);
        check("bars_x160", cap_rgb[160], 24'h00FF00);
        check("bars_x560", cap_rgb[560], 24'hFFFFFF);
        check("bars_x639", cap_rgb[639], 24'hFFFFFF);

        // checkerboard; mode switched to grey mid-frame
        send_frame(8, 3, 2'd3);
        check("check_x0", cap_rgb[0], 24'h000000);
        check("check_x32", cap_rgb[32], 24'hFFFFFF);
        check("check_x64", cap_rgb[64], 24'h000000);

        // grey after the next vsync
        send_frame(0, -1, 2'd0);
        check("grey_f4", cap_rgb[10], 24'h040404);
        check("frame_after5", bus.frame, 8'd5);

        // saturation: long active line then 500 short lines in one frame
        bus.mode = 2'd0;
        send_line(0, 8, 1'b0, 1'b0);
        send_line(0, 4, 1'b1, 1'b0);
        send_line(0, 4, 1'b0, 1'b0);
        send_line(700, 16, 1'b0, 1'b1);
        check("xsat_638", cap_rgb[638], 24'h7E8406);
        check("xsat_639", cap_rgb[639], 24'h7F8506);
        check("xsat_699", cap_rgb[699], 24'h7F8506);
        for (int i = 0; i < 500; i++) begin
            send_line(2, 1, 1'b0, (i == 477) || (i == 499));
            if (i == 477)
                check("y478", cap_rgb[0], 24'hDEE4D8);
        end
        check("ysat_479", cap_rgb[0], 24'hDFE5D9);

        // frame wrap in grey mode
        bus.mode = 2'd3;
        send_line(0, 8, 1'b0, 1'b0);
        for (int i = 0; i < 249; i++) begin
            send_line(0, 2, 1'b1, 1'b0);
            send_line(0, 2, 1'b0, 1'b0);
        end
        check("frame_255", bus.frame, 8'hFF);
        send_line(0, 2, 1'b1, 1'b0);
        send_line(0, 2, 1'b0, 1'b0);
        check("frame_wrap0", bus.frame, 8'h00);
        send_line(8, 4, 1'b0, 1'b1);
        check("grey_wrap_rgb", cap_rgb[3], 24'h000000);
        check("grey_wrap_active", cap_bl[3], 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-colour stage directly downstream of the VGA sync generator on the DE2-115. It consumes the generator's registered `hs`/`vs`/`blank_n` and recovers the pixel coordinates from them. It produces 8-bit RGB test patterns (animated XOR, colour bars, checkerboard, grey ramp). All sync signals are delayed to stay aligned with the colour data going to the ADV7123 DAC.

## Interface
- `H_ACTIVE`, 640: visible pixels per line; the x counter saturates at `H_ACTIVE-1`.
- `V_ACTIVE`, 480: visible lines per frame; the y counter saturates at `V_ACTIVE-1`.
- `BAR_W`, 80: pixels per colour bar (`H_ACTIVE/8`).
- `clk` in 1: pixel clock, same clock as the sync generator. This block uses the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hs_in` in 1: horizontal sync from the generator, active low.
- `vs_in` in 1: vertical sync from the generator, active low.
- `blank_n_in` in 1: high during the visible area.
- `mode` in 2: requested pattern, from slide switches (asynchronous, quasi-static).
- `hs` out 1: `hs_in` delayed 2 cycles.
- `vs` out 1: `vs_in` delayed 2 cycles.
- `blank_n` out 1: `blank_n_in` delayed 2 cycles.
- `r`, `g`, `b` out 8 each: colour data, aligned with `blank_n`.
- `frame` out 8: frame counter, wraps at 256.

## Operation
- **Stage 0: coordinate tracking.** Updates on every rising edge of `clk`.
  - `x_cnt`: cleared to 0 whenever `blank_n_in`=0. Otherwise the sample is tagged `x=x_cnt`, then `x_cnt` increments, saturating at `H_ACTIVE-1`.
  - `y_cnt`: cleared to 0 whenever `vs_in`=0. Otherwise it increments on each falling edge of `blank_n_in` (previous sample 1, current sample 0), saturating at `V_ACTIVE-1`.
  - `bar_cnt`/`bar_idx`: cleared while `blank_n_in`=0. While active, `bar_cnt` counts 0..`BAR_W-1`. On wrap, `bar_idx` increments, saturating at 7.
  - `frame`: increments (mod 256) on each falling edge of `vs_in`.
  - `mode_act`: captures `mode` on the same `vs_in` falling edge, so a pattern change never tears mid-frame. `mode` passes through a 2-flop synchroniser first.
- **Stage 1.** Registers `x`, `y`, `bar_idx`, `hs_in`, `vs_in` and `blank_n_in`.
- **Stage 2.** Computes the colour from the stage-1 values, `frame` and `mode_act`, then registers the outputs. Only x[7:0] and y[7:0] are used; the arithmetic is mod 256. `frame` is the live `frame` counter value at the time stage 2 computes, so in the first visible line after a vsync falling edge it already includes that increment.
  - mode 0 (XOR): `p=x^y`; `r=p`, `g=p+frame`, `b=y^frame`.
  - mode 1 (bars): `r=bar_idx[2]?FF:00`, `g=bar_idx[1]?FF:00`, `b=bar_idx[0]?FF:00`.
  - mode 2 (checker, 32-px squares): all channels = `(x[5]^y[5])?FF:00`.
  - mode 3 (grey): `r=g=b=frame`.
- **Blanking.** When stage-1 blank is 0, `r`/`g`/`b` are forced to 0 regardless of mode.

## Timing
- **Reset values** (asserted asynchronously): `hs`=1, `vs`=1, `blank_n`=0, `r`=`g`=`b`=0, `frame`=0, `mode_act`=0. All counters and pipeline registers are 0, except the sync pipeline flops, which reset to 1.
- **Latency.** Exactly 2 rising edges from input to output for `hs`, `vs`, `blank_n` and colour. The relative alignment of the three sync signals is preserved.
- **Input timing.** Inputs change on the falling edge of `clk`. Sampling on the rising edge gives half a period of setup and needs no synchronisers. `mode` is the only asynchronous input.
- **Simultaneous events.** Clearing wins over incrementing: `vs_in`=0 together with a `blank_n_in` fall leaves `y_cnt`=0.
- **Reset mid-frame.** The outputs take their reset values at once. After release, the coordinates are correct from the next `vs_in` low; until then `y` may be offset, which is acceptable.
- **Wrap.** `frame` goes 255→0 with no side effects.

## Structure
- Package `vga_pkg`:
  - default `H_ACTIVE`/`V_ACTIVE`/`BAR_W` constants;
  - 2-bit mode encodings `MODE_XOR=0`, `MODE_BARS=1`, `MODE_CHECK=2`, `MODE_GREY=3`.
- Sub-module `vga_pos_tracker`: stage 0 (x/y/bar counters, edge detects, `frame`, `mode_act` capture). `vga_pattern_gen` instantiates it and owns stages 1–2.

## Test plan
- **Reset.** Drive `rst_n`=0 mid-line → all outputs take their reset values asynchronously. Release `rst_n`, then drive constant-high `hs_in`/`vs_in`/`blank_n_in` → outputs follow the inputs after exactly 2 cycles.
- **XOR pattern.** Drive the standard 800×525 timing with `mode`=0, then check the first visible line after the first vsync → frame=1; pixel (x=5, y=0) gives `r`=05, `g`=06, `b`=01. Every blanked sample gives RGB=0.
- **Bars.** `mode`=1, line y=10 → x=0..79 give RGB=000000; x=80 gives 0000FF; x=560..639 give FFFFFF.
- **Mode change.** Change `mode` from 2 to 3 mid-frame → the pattern is unchanged until the next `vs_in` falling edge. After it, the output is grey equal to the new `frame` value.
- **Frame wrap.** Drive 256 vsyncs → `frame` returns to 0; at that frame, mode-3 grey is 00.
- **Saturation.** Hold `blank_n_in` high for 700 cycles → the x tag sticks at 639. Drive 500 active lines in one frame → y sticks at 479.
